// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, response codes and the
// default-slave state encoding used by the decoder/mux slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // A transfer carries data only for NONSEQ and SEQ; IDLE and BUSY are
    // answered zero-wait OKAY by every slave, including the default one.
    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers NONSEQ/SEQ with the
// two-cycle AHB ERROR response and counts those errors, saturating.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hready,
    input  logic                hsel_default,
    input  logic [1:0]          htrans,
    output logic                hreadyout_d,
    output logic                hresp_d,
    output logic [ERRCNT_W-1:0] err_cnt
);

    ds_state_t state;
    logic      err_start;

    // An erroring transfer is one accepted into the default slave's data phase.
    assign err_start = hready && hsel_default && trans_active(htrans);

    // Error-response FSM with registered ready/response and the error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DS_IDLE;
            hreadyout_d <= 1'b1;
            hresp_d     <= HRESP_OKAY;
            err_cnt     <= '0;
        end else begin
            case (state)
                DS_IDLE, DS_ERR2: begin
                    if (err_start) begin
                        state       <= DS_ERR1;
                        hreadyout_d <= 1'b0;
                        hresp_d     <= HRESP_ERROR;
                        if (err_cnt != {ERRCNT_W{1'b1}}) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        state       <= DS_IDLE;
                        hreadyout_d <= 1'b1;
                        hresp_d     <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state       <= DS_ERR2;
                    hreadyout_d <= 1'b1;
                    hresp_d     <= HRESP_ERROR;
                end
                default: begin
                    state       <= DS_IDLE;
                    hreadyout_d <= 1'b1;
                    hresp_d     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder with data-phase select register, slave response
// multiplexer and an embedded default slave for unmapped addresses.
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int unsigned                  NUM_SLAVES = 4,
    parameter int unsigned                  ADDR_W     = 32,
    parameter int unsigned                  DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h4000_0000, 32'h3000_0000,
                                                          32'h2000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {4{32'hF800_0000}},
    parameter int unsigned                  REMAP_SLV  = 3,
    parameter int unsigned                  ERRCNT_W   = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         REMAP,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    output logic                         HSELDefault,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [ERRCNT_W-1:0]          ERR_CNT
);

    // Data-phase select: one bit per slave plus the default slave in the MSB.
    localparam logic [NUM_SLAVES:0] SEL_DEFAULT = {1'b1, {NUM_SLAVES{1'b0}}};

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_hit;
    logic [NUM_SLAVES:0]   sel_q;
    logic [DATA_W-1:0]     rdata_mux;
    logic                  ready_mux;
    logic                  resp_mux;
    logic                  hreadyout_d;
    logic                  hresp_d;

    // Priority address decode (lowest matching index wins) with slave-0 remap.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit &&
                ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                dec_hit    = 1'b1;
                dec_sel[i] = 1'b1;
            end
        end
        if (REMAP && dec_sel[0]) begin
            dec_sel[0]         = 1'b0;
            dec_sel[REMAP_SLV] = 1'b1;
        end
    end

    assign HSEL_S      = HRESETn ? dec_sel : '0;
    assign HSELDefault = !HRESETn || !dec_hit;

    // Capture the address-phase select when the bus accepts it; hold on stalls.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= SEL_DEFAULT;
        end else if (HREADY) begin
            sel_q <= {HSELDefault, HSEL_S};
        end
    end

    // Steer the selected slave's data-phase signals back to the master.
    always_comb begin
        rdata_mux = '0;
        ready_mux = 1'b0;
        resp_mux  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_mux = rdata_mux | HRDATA_S[i*DATA_W +: DATA_W];
                ready_mux = ready_mux | HREADYOUT_S[i];
                resp_mux  = resp_mux  | HRESP_S[i];
            end
        end
        if (sel_q[NUM_SLAVES]) begin
            rdata_mux = '0;
            ready_mux = hreadyout_d;
            resp_mux  = hresp_d;
        end
    end

    assign HRDATA = rdata_mux;
    assign HREADY = ready_mux;
    assign HRESP  = resp_mux;

    ahb_default_slave #(
        .ERRCNT_W (ERRCNT_W)
    ) u_default_slave (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .hready       (HREADY),
        .hsel_default (HSELDefault),
        .htrans       (HTRANS),
        .hreadyout_d  (hreadyout_d),
        .hresp_d      (hresp_d),
        .err_cnt      (ERR_CNT)
    );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Scoreboard bench for ahb_decoder_mux: directed transfers push their
// expected select/data/response into a queue; a monitor pops and compares.
module tb_ahb_decoder_mux;
    import ahb_pkg::*;

    localparam int NS = 4;

    localparam logic [31:0] LANE0 = 32'hD05A_5A5A;
    localparam logic [31:0] LANE1 = 32'hD15A_5A5A;
    localparam logic [31:0] LANE2 = 32'hD25A_5A5A;
    localparam logic [31:0] LANE3 = 32'hD35A_5A5A;

    localparam logic [4:0] SEL0 = 5'b00001;
    localparam logic [4:0] SEL1 = 5'b00010;
    localparam logic [4:0] SEL2 = 5'b00100;
    localparam logic [4:0] SEL3 = 5'b01000;
    localparam logic [4:0] SELD = 5'b10000;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        logic [1:0]  errcnt;
    } txn_t;

    logic             HCLK;
    logic             HRESETn;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             REMAP;
    logic [NS-1:0]    HSEL_S;
    logic             HSELDefault;
    logic [NS*32-1:0] HRDATA_S;
    logic [NS-1:0]    HREADYOUT_S;
    logic [NS-1:0]    HRESP_S;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;
    logic [1:0]       ERR_CNT;

    txn_t sb_q[$];
    logic track;
    logic done;
    int   errors;
    int   checks;

    ahb_decoder_mux #(
        .ERRCNT_W (2)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .REMAP       (REMAP),
        .HSEL_S      (HSEL_S),
        .HSELDefault (HSELDefault),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .ERR_CNT     (ERR_CNT)
    );

    // Free-running clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Global safety net in case something never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic txn_t mk(input logic [4:0] sel, input logic [31:0] rdata,
                                input logic resp, input int waits, input logic [1:0] errcnt);
        txn_t t;
        t.sel    = sel;
        t.rdata  = rdata;
        t.resp   = resp;
        t.waits  = waits;
        t.errcnt = errcnt;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic waitAccept();
        for (int c = 0; c < 20; c++) begin
            @(negedge HCLK);
            if (HREADY) return;
        end
        $display("[TB] FAIL accept_timeout: HREADY stayed 0 for 20 cycles, expected 1");
        $fatal(1, "[TB] address phase never accepted");
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                                 input logic remap, input txn_t exp);
        @(posedge HCLK);
        #2;
        HADDR  = addr;
        HTRANS = trans;
        REMAP  = remap;
        track  = 1'b1;
        sb_q.push_back(exp);
        waitAccept();
    endtask

    // Stimulus: directed transfers with hand-computed expectations.
    initial begin
        errors      = 0;
        checks      = 0;
        done        = 1'b0;
        track       = 1'b0;
        HRESETn     = 1'b0;
        HADDR       = 32'h2000_0000;
        HTRANS      = HTRANS_NONSEQ;
        REMAP       = 1'b0;
        HREADYOUT_S = '1;
        HRESP_S     = '0;
        HRDATA_S    = {LANE3, LANE2, LANE1, LANE0};

        repeat (3) @(negedge HCLK);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        HTRANS  = HTRANS_IDLE;

        // Decode map across all slaves, then an unmapped NONSEQ.
        applyStimulus(32'h0000_0010, HTRANS_NONSEQ, 1'b0, mk(SEL0, LANE0, 1'b0, 0, 2'd0));
        applyStimulus(32'h2000_0000, HTRANS_NONSEQ, 1'b0, mk(SEL1, LANE1, 1'b0, 0, 2'd0));
        applyStimulus(32'h3000_0004, HTRANS_SEQ,    1'b0, mk(SEL2, LANE2, 1'b0, 0, 2'd0));
        applyStimulus(32'h4000_0000, HTRANS_NONSEQ, 1'b0, mk(SEL3, LANE3, 1'b0, 0, 2'd0));
        applyStimulus(32'h1000_0000, HTRANS_NONSEQ, 1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd1));

        // Slave 1 stalls three cycles while slave 3's address phase waits.
        applyStimulus(32'h2000_0000, HTRANS_NONSEQ, 1'b0, mk(SEL1, LANE1, 1'b0, 3, 2'd1));
        @(posedge HCLK);
        #2;
        HADDR          = 32'h4000_0000;
        HTRANS         = HTRANS_NONSEQ;
        HREADYOUT_S[1] = 1'b0;
        sb_q.push_back(mk(SEL3, LANE3, 1'b0, 0, 2'd1));
        repeat (2) @(posedge HCLK);
        @(posedge HCLK);
        #2;
        HREADYOUT_S[1] = 1'b1;
        waitAccept();

        // Single error, then IDLE and BUSY to the same unmapped address.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd2));
        applyStimulus(32'h5000_0000, HTRANS_IDLE,   1'b0, mk(SELD, 32'h0, 1'b0, 0, 2'd2));
        applyStimulus(32'h5000_0000, HTRANS_BUSY,   1'b0, mk(SELD, 32'h0, 1'b0, 0, 2'd2));

        // Back-to-back errors; the 2-bit counter saturates at 3.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd3));
        applyStimulus(32'h5000_0004, HTRANS_SEQ,    1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd3));
        applyStimulus(32'h5000_0008, HTRANS_NONSEQ, 1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd3));

        // Remap redirects only the slave-0 region.
        applyStimulus(32'h0000_0100, HTRANS_NONSEQ, 1'b1, mk(SEL3, LANE3, 1'b0, 0, 2'd3));
        applyStimulus(32'h2000_0000, HTRANS_NONSEQ, 1'b1, mk(SEL1, LANE1, 1'b0, 0, 2'd3));
        applyStimulus(32'h0000_0100, HTRANS_NONSEQ, 1'b0, mk(SEL0, LANE0, 1'b0, 0, 2'd3));

        // Reset asserted during the ERR1 cycle of an error transfer.
        applyStimulus(32'h5000_0000, HTRANS_NONSEQ, 1'b0, mk(SELD, 32'h0, 1'b1, 1, 2'd3));
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        HTRANS  = HTRANS_IDLE;
        track   = 1'b0;
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;

        applyStimulus(32'h3000_0000, HTRANS_NONSEQ, 1'b0, mk(SEL2, LANE2, 1'b0, 0, 2'd0));

        @(posedge HCLK);
        #2;
        HTRANS = HTRANS_IDLE;
        track  = 1'b0;
        repeat (3) @(posedge HCLK);
        #2;
        done = 1'b1;
    end

    // Monitor: pops expectations on accepted address phases and compares
    // the data phase when the DUT completes it.
    initial begin
        txn_t cur;
        logic dp_valid;
        int   dp_waits;
        dp_valid = 1'b0;
        dp_waits = 0;
        cur      = mk(SELD, 32'h0, 1'b0, 0, 2'd0);
        forever begin
            @(negedge HCLK);
            if (done) begin
                checkOutput("sb_drained", 32'(sb_q.size()) + 32'(dp_valid), 32'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else if (!HRESETn) begin
                checkOutput("rst_hsel",    32'(HSEL_S),      32'd0);
                checkOutput("rst_hseldef", 32'(HSELDefault), 32'd1);
                checkOutput("rst_hready",  32'(HREADY),      32'd1);
                checkOutput("rst_hresp",   32'(HRESP),       32'd0);
                checkOutput("rst_hrdata",  HRDATA,           32'd0);
                checkOutput("rst_errcnt",  32'(ERR_CNT),     32'd0);
                sb_q.delete();
                dp_valid = 1'b0;
                dp_waits = 0;
            end else begin
                if (dp_valid) begin
                    if (!HREADY) begin
                        dp_waits++;
                        checkOutput("wait_hresp", 32'(HRESP), 32'(cur.resp));
                        if (dp_waits > 10) begin
                            checkOutput("wait_bound", 32'(dp_waits), 32'(cur.waits));
                            dp_valid = 1'b0;
                        end
                    end else begin
                        checkOutput("data_hrdata", HRDATA,           cur.rdata);
                        checkOutput("data_hresp",  32'(HRESP),       32'(cur.resp));
                        checkOutput("data_waits",  32'(dp_waits),    32'(cur.waits));
                        checkOutput("data_errcnt", 32'(ERR_CNT),     32'(cur.errcnt));
                        dp_valid = 1'b0;
                    end
                end
                if (track && HREADY) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        cur = sb_q.pop_front();
                        checkOutput("addr_sel", 32'({HSELDefault, HSEL_S}), 32'(cur.sel));
                        dp_valid = 1'b1;
                        dp_waits = 0;
                    end
                end
            end
        end
    end

endmodule
